// File: rtl/aes_req_arbiter_pkg.sv
// Shared types for the AES request arbiter: FSM state encoding, block width
// and the text/key job bundle handed from a requester to the cipher.
package aes_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BUSY,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic [AES_BLK_W-1:0] key;
        logic [AES_BLK_W-1:0] text;
    } aes_job_t;

endpackage

// File: rtl/aes_req_arbiter_if.sv
// Requester/consumer side of the AES arbiter: per-requester job handshakes
// plus the single tagged response port.
interface aes_req_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import aes_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [AES_BLK_W*NUM_REQ-1:0] req_text;
    logic [AES_BLK_W*NUM_REQ-1:0] req_key;
    logic                         resp_valid;
    logic                         resp_ready;
    logic [ID_W-1:0]              resp_id;
    logic [AES_BLK_W-1:0]         resp_text;
    logic                         resp_err;

    modport master (
        output req_valid, req_text, req_key, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_text, resp_err
    );

    modport slave (
        input  req_valid, req_text, req_key, resp_ready,
        output req_ready, resp_valid, resp_id, resp_text, resp_err
    );

endinterface

// File: rtl/aes_rr_pick.sv
// Combinational round-robin picker: first asserted valid at or above ptr,
// wrapping modulo NUM_REQ.
module aes_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt_onehot,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       any
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!any && valid[idx]) begin
                any             = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES cipher core among NUM_REQ requesters, one job in flight.
// Optional BUSY watchdog enabled by defining AES_ARB_TIMEOUT_EN.
module aes_req_arbiter
    import aes_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_req_arbiter_if.slave     bus,
    output logic                 cipher_ld,
    output logic [AES_BLK_W-1:0] cipher_key,
    output logic [AES_BLK_W-1:0] cipher_text,
    input  logic                 cipher_done,
    input  logic [AES_BLK_W-1:0] cipher_text_out,
    output logic                 busy
);
    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_t           state;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      grant_id;
    logic [ID_W-1:0]      next_ptr;
    logic [NUM_REQ-1:0]   gnt_onehot;
    logic [ID_W-1:0]      gnt_idx;
    logic                 gnt_any;
    logic                 tmo_hit;
    logic                 resp_valid_q;
    logic                 resp_err_q;
    logic [ID_W-1:0]      resp_id_q;
    logic [AES_BLK_W-1:0] resp_text_q;
    aes_job_t             jobs [NUM_REQ];
    aes_job_t             sel_job;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_job
        assign jobs[i].key  = bus.req_key[i*AES_BLK_W +: AES_BLK_W];
        assign jobs[i].text = bus.req_text[i*AES_BLK_W +: AES_BLK_W];
    end

    assign sel_job = jobs[gnt_idx];

    aes_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid      (bus.req_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    // Gated by rst so no requester sees an accept while the FSM is held in reset.
    assign bus.req_ready = (state == IDLE && rst) ? gnt_onehot : '0;

    assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Fires in the TIMEOUT_CYCLES-th BUSY cycle; cipher_done in that cycle still wins.
    assign tmo_hit = (state == BUSY) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state == LOAD) begin
            tmo_cnt <= '0;
        end else if (state == BUSY) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    // Constant 0: BUSY waits for cipher_done indefinitely.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            cipher_ld    <= 1'b0;
            cipher_key   <= '0;
            cipher_text  <= '0;
            busy         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_id_q    <= '0;
            resp_text_q  <= '0;
        end else begin
            cipher_ld <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gnt_any) begin
                        state       <= LOAD;
                        grant_id    <= gnt_idx;
                        cipher_key  <= sel_job.key;
                        cipher_text <= sel_job.text;
                        cipher_ld   <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                LOAD: state <= BUSY;
                BUSY: begin
                    if (cipher_done) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_id_q    <= grant_id;
                        resp_text_q  <= cipher_text_out;
                    end else if (tmo_hit) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_id_q    <= grant_id;
                        resp_text_q  <= '0;
                    end
                end
                RESP: begin
                    // Pointer advances only here, so a stalled consumer cannot skew fairness.
                    if (bus.resp_ready) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b0;
                        rr_ptr       <= next_ptr;
                        busy         <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_text  = resp_text_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter with a cycle-level transaction model and a
// stub cipher; define AES_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_aes_req_arbiter;
    import aes_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 8;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         cipher_ld, busy, cipher_done;
    logic         auto_done = 1'b0;
    logic         spur_done = 1'b0;
    logic [127:0] cipher_key, cipher_text, cipher_text_out;
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           auto_cnt = 0;
    int           auto_lat = 5;
    bit           auto_en = 1'b1;
    int           dut_acc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_req_arbiter_if #(.NUM_REQ(N)) bus ();

    aes_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .cipher_ld       (cipher_ld),
        .cipher_key      (cipher_key),
        .cipher_text     (cipher_text),
        .cipher_done     (cipher_done),
        .cipher_text_out (cipher_text_out),
        .busy            (busy)
    );

    // Stub cipher: knows the FIPS-197 vector, otherwise a fixed scramble.
    function automatic logic [127:0] stub(input logic [127:0] k, input logic [127:0] t);
        if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
        return k ^ {t[63:0], t[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    assign cipher_text_out = stub(cipher_key, cipher_text);
    assign cipher_done     = auto_done | spur_done;

    // done pulses auto_lat cycles after the load cycle
    always @(negedge clk) begin
        if (!rst) begin
            auto_cnt  <= 0;
            auto_done <= 1'b0;
        end else if (cipher_ld && auto_en) begin
            auto_cnt  <= auto_lat;
            auto_done <= 1'b0;
        end else if (auto_cnt > 0) begin
            auto_cnt  <= auto_cnt - 1;
            auto_done <= (auto_cnt == 1);
        end else begin
            auto_done <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Model: phase 0 no job, 1 loading, 2 waiting on cipher, 3 result offered.
    int           m_phase = 0, m_ptr = 0, m_gid = 0, m_wait = 0, m_rid = 0;
    logic [127:0] m_key = '0, m_text = '0, m_rtext = '0;
    logic         m_rerr = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= 0; m_ptr <= 0; m_gid <= 0; m_wait <= 0; m_rid <= 0;
            m_key <= '0; m_text <= '0; m_rtext <= '0; m_rerr <= 1'b0;
        end else begin
            case (m_phase)
                0: if (pick(bus.req_valid, m_ptr) >= 0) begin
                    m_gid   <= pick(bus.req_valid, m_ptr);
                    m_key   <= bus.req_key[128*pick(bus.req_valid, m_ptr) +: 128];
                    m_text  <= bus.req_text[128*pick(bus.req_valid, m_ptr) +: 128];
                    m_phase <= 1;
                end
                1: begin m_phase <= 2; m_wait <= 0; end
                2: begin
                    if (cipher_done) begin
                        m_rtext <= cipher_text_out; m_rerr <= 1'b0; m_rid <= m_gid; m_phase <= 3;
                    end
`ifdef AES_ARB_TIMEOUT_EN
                    else if (m_wait + 1 == TMO) begin
                        m_rtext <= '0; m_rerr <= 1'b1; m_rid <= m_gid; m_phase <= 3;
                    end
`endif
                    else m_wait <= m_wait + 1;
                end
                3: if (bus.resp_ready) begin m_ptr <= (m_gid + 1) % N; m_phase <= 0; end
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin : cmp
        logic [N-1:0] exp_rdy;
        exp_rdy = '0;
        if (rst && m_phase == 0 && pick(bus.req_valid, m_ptr) >= 0)
            exp_rdy[pick(bus.req_valid, m_ptr)] = 1'b1;
        chk("req_ready",   128'(bus.req_ready),  128'(exp_rdy));
        chk("cipher_ld",   128'(cipher_ld),      128'(m_phase == 1));
        chk("busy",        128'(busy),           128'(m_phase != 0));
        chk("resp_valid",  128'(bus.resp_valid), 128'(m_phase == 3));
        chk("resp_id",     128'(bus.resp_id),    128'(m_rid));
        chk("resp_err",    128'(bus.resp_err),   128'(m_rerr));
        chk("resp_text",   bus.resp_text,        m_rtext);
        chk("cipher_key",  cipher_key,           m_key);
        chk("cipher_text", cipher_text,          m_text);
    end

    always @(negedge clk)
        if (rst && bus.req_ready != '0)
            for (int i = 0; i < N; i++) if (bus.req_ready[i]) dut_acc.push_back(i);

    task automatic wait_rdy(input int idx, input string nm);
        logic f;
        f = 1'b0;
        for (int i = 0; i < 100 && !f; i++) begin @(negedge clk); f = bus.req_ready[idx]; end
        chk(nm, 128'(f), 128'(1));
    endtask

    task automatic wait_ld(input string nm);
        logic f;
        f = 1'b0;
        for (int i = 0; i < 100 && !f; i++) begin @(negedge clk); f = cipher_ld; end
        chk(nm, 128'(f), 128'(1));
    endtask

    task automatic wait_resp(input string nm);
        logic f;
        f = 1'b0;
        for (int i = 0; i < 100 && !f; i++) begin @(negedge clk); f = bus.resp_valid; end
        chk(nm, 128'(f), 128'(1));
    endtask

    task automatic wait_idle(input string nm);
        logic f;
        f = 1'b0;
        for (int i = 0; i < 100 && !f; i++) begin @(negedge clk); f = !busy; end
        chk(nm, 128'(f), 128'(1));
    endtask

    task automatic rst_outputs_zero(input string nm);
        chk({nm, "_busy"},   128'(busy),           128'(0));
        chk({nm, "_rv"},     128'(bus.resp_valid), 128'(0));
        chk({nm, "_ld"},     128'(cipher_ld),      128'(0));
        chk({nm, "_rdy"},    128'(bus.req_ready),  128'(0));
        chk({nm, "_key"},    cipher_key,           128'(0));
        chk({nm, "_text"},   cipher_text,          128'(0));
        chk({nm, "_rid"},    128'(bus.resp_id),    128'(0));
        chk({nm, "_rtext"},  bus.resp_text,        128'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [1:0]   hid;
        logic [127:0] htext;
        int           c0;
        int           rr_exp[5] = '{0, 1, 2, 3, 0};

        bus.req_valid = '0; bus.req_text = '0; bus.req_key = '0; bus.resp_ready = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1 rst_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // FIPS-197 vector from requester 2
        bus.req_key[2*128 +: 128]  = FIPS_KEY;
        bus.req_text[2*128 +: 128] = FIPS_PT;
        bus.req_valid  = 4'b0100;
        bus.resp_ready = 1'b1;
        wait_rdy(2, "fips_accept");
        @(posedge clk); #1 bus.req_valid = '0;
        @(negedge clk);
        chk("fips_ld_lat", 128'(cipher_ld), 128'(1));
        chk("fips_key", cipher_key, FIPS_KEY);
        @(negedge clk);
        chk("fips_ld_pulse", 128'(cipher_ld), 128'(0));
        wait_resp("fips_resp");
        chk("fips_ct", bus.resp_text, FIPS_CT);
        chk("fips_id", 128'(bus.resp_id), 128'(2));
        chk("fips_err", 128'(bus.resp_err), 128'(0));

        // All requesters valid from reset: round-robin order
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.req_key[i*128 +: 128]  = {4{32'h1000_0000 + i}};
            bus.req_text[i*128 +: 128] = {4{32'hA5A5_0000 + i}};
        end
        bus.req_valid = '1;
        dut_acc.delete();
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 400 && dut_acc.size() < 5; i++) @(negedge clk);
        chk("rr_count", 128'(dut_acc.size()), 128'(5));
        for (int k = 0; k < 5 && k < dut_acc.size(); k++) chk("rr_order", 128'(dut_acc[k]), 128'(rr_exp[k]));

        // Consumer stall for 10 cycles in RESP
        @(posedge clk); #1 bus.resp_ready = 1'b0;
        wait_resp("hold_resp");
        hid = bus.resp_id; htext = bus.resp_text;
        chk("hold_id0", 128'(hid), 128'(0));
        chk("hold_text0", htext, stub({4{32'h1000_0000}}, {4{32'hA5A5_0000}}));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_rv", 128'(bus.resp_valid), 128'(1));
            chk("hold_id", 128'(bus.resp_id), 128'(hid));
            chk("hold_text", bus.resp_text, htext);
            chk("hold_rdy", 128'(bus.req_ready), 128'(0));
        end
        @(posedge clk); #1 bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("hold_rdy_still", 128'(bus.req_ready), 128'(0));
        @(negedge clk);
        chk("post_hs_accept", 128'(bus.req_ready), 128'(4'b0010));

        // Spurious cipher_done in IDLE and LOAD
        @(posedge clk); #1 bus.req_valid = '0;
        wait_idle("drain1");
        @(posedge clk); #1 spur_done = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("spur_idle_rv", 128'(bus.resp_valid), 128'(0));
            chk("spur_idle_busy", 128'(busy), 128'(0));
        end
        @(posedge clk); #1 spur_done = 1'b0; bus.req_valid = 4'b1000;
        wait_rdy(3, "spur_accept");
        @(posedge clk); #1 bus.req_valid = '0; spur_done = 1'b1;
        @(negedge clk);
        chk("spur_load_ld", 128'(cipher_ld), 128'(1));
        @(posedge clk); #1 spur_done = 1'b0;
        @(negedge clk);
        chk("spur_load_rv", 128'(bus.resp_valid), 128'(0));
        wait_resp("spur_resp");
        chk("spur_id", 128'(bus.resp_id), 128'(3));
        @(negedge clk);
        chk("spur_single", 128'(bus.resp_valid), 128'(0));

        // Reset while BUSY
        auto_lat = 20;
        bus.req_valid = 4'b1010;
        wait_ld("rst_ld");
        @(posedge clk); #1 rst = 1'b0;
        #1 rst_outputs_zero("midrst");
        bus.req_valid = '1;
        auto_lat = 5;
        dut_acc.delete();
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 50 && dut_acc.size() < 1; i++) @(negedge clk);
        chk("midrst_acc", 128'(dut_acc.size() >= 1), 128'(1));
        if (dut_acc.size() >= 1) chk("midrst_first", 128'(dut_acc[0]), 128'(0));
        @(posedge clk); #1 bus.req_valid = '0;
        wait_idle("drain2");

`ifdef AES_ARB_TIMEOUT_EN
        // Watchdog: no done -> error after 8 BUSY cycles
        auto_en = 1'b0;
        bus.req_valid = 4'b0100;
        wait_rdy(2, "tmo_accept");
        @(posedge clk); #1 bus.req_valid = '0;
        wait_ld("tmo_ld");
        c0 = cyc;
        wait_resp("tmo_resp");
        chk("tmo_delay", 128'(cyc - c0), 128'(9));
        chk("tmo_err", 128'(bus.resp_err), 128'(1));
        chk("tmo_text", bus.resp_text, 128'(0));
        chk("tmo_id", 128'(bus.resp_id), 128'(2));
        wait_idle("drain3");

        // done in the limit cycle wins
        auto_en = 1'b1; auto_lat = 8;
        bus.req_valid = 4'b1000;
        wait_rdy(3, "lim_accept");
        @(posedge clk); #1 bus.req_valid = '0;
        wait_ld("lim_ld");
        c0 = cyc;
        wait_resp("lim_resp");
        chk("lim_delay", 128'(cyc - c0), 128'(9));
        chk("lim_err", 128'(bus.resp_err), 128'(0));
        chk("lim_text", bus.resp_text, stub({4{32'h1000_0003}}, {4{32'hA5A5_0003}}));
        wait_idle("drain4");
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_req_arbiter.md
# aes_req_arbiter

Round-robin arbiter and sequencer that shares one `aes_cipher_top` instance among `NUM_REQ` requesters. It accepts one text/key job at a time over per-requester valid/ready handshakes and drives the cipher's `ld`/`key`/`text_in`. It waits for `done`, then returns the ciphertext tagged with the requester index over a single valid/ready response port. It sits between the requester clients and the cipher core, in place of direct buffer-to-cipher wiring.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 32: watchdog limit in BUSY. Used only with `AES_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: job offered, one bit per requester.
- `req_ready` out NUM_REQ: job accepted; one-hot or zero.
- `req_text` in 128*NUM_REQ: plaintext; slice i is `[128*i +: 128]`.
- `req_key` in 128*NUM_REQ: key; slice i as above.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer accepts result.
- `resp_id` out $clog2(NUM_REQ): index of the requester that owns the result.
- `resp_text` out 128: ciphertext.
- `resp_err` out 1: result is a timeout error.
- `cipher_ld` out 1: one-cycle load strobe to the cipher.
- `cipher_key` out 128: registered key to the cipher.
- `cipher_text` out 128: registered plaintext to the cipher.
- `cipher_done` in 1: cipher completion strobe.
- `cipher_text_out` in 128: cipher result.
- `busy` out 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: no job in flight.
  - LOAD: cipher is being loaded.
  - BUSY: waiting for `cipher_done`.
  - RESP: result waiting for the consumer.
- IDLE:
  - Search from `rr_ptr` upward, modulo `NUM_REQ`, for the first asserted `req_valid`.
  - If one is found, assert `req_ready[g]` combinationally that cycle.
  - Latch `req_text[g]`, `req_key[g]` into `cipher_text`/`cipher_key` and `g` into `grant_id`.
  - Go to LOAD.
- LOAD: assert `cipher_ld`=1 for exactly this cycle, then go to BUSY.
- BUSY:
  - On `cipher_done`, latch `cipher_text_out` into `resp_text`.
  - Set `resp_valid`=1, `resp_err`=0 and `resp_id`=`grant_id`, then go to RESP.
- RESP:
  - Hold all `resp_*` outputs stable while `resp_ready`=0.
  - On `resp_valid && resp_ready`, clear `resp_valid`, set `rr_ptr` = (`grant_id`+1) mod `NUM_REQ`, and go to IDLE.
- Only one job is in flight. `req_ready` is 0 in every state except IDLE.
- `cipher_done` outside BUSY is ignored and never produces a response.
- A requester that drops `req_valid` before it is granted loses nothing; no state is kept per requester.
- `rr_ptr` moves only on response completion, never on grant.

## Timing
- Reset values:
  - state=IDLE, `rr_ptr`=0, `grant_id`=0.
  - `req_ready`=0, `resp_valid`=0, `resp_err`=0, `resp_id`=0.
  - `resp_text`=0, `cipher_ld`=0, `cipher_key`=0, `cipher_text`=0, `busy`=0.
- Latency:
  - `cipher_ld` rises 1 cycle after the accept cycle.
  - `resp_valid` rises 1 cycle after the `cipher_done` cycle.
- Throughput: the earliest next accept is the cycle after the response handshake. Minimum overhead is 3 cycles plus cipher latency.
- Reset mid-operation drops the job silently and returns to IDLE. `cipher_ld` deasserts immediately. The cipher shares the same `rst`.
- `resp_ready` held high in RESP: the response completes in one cycle.

## Configuration
- `AES_ARB_TIMEOUT_EN` defined:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches `TIMEOUT_CYCLES` without `cipher_done`, go to RESP with `resp_err`=1 and `resp_text`=0.
  - `cipher_done` in the same cycle as the limit wins, giving a normal response.
- `AES_ARB_TIMEOUT_EN` not defined:
  - No counter; BUSY waits indefinitely.
  - `resp_err` is tied to 0 and `TIMEOUT_CYCLES` is unused.

## Structure
- Package `aes_pkg`:
  - state enum `arb_state_t` {IDLE, LOAD, BUSY, RESP};
  - `AES_BLK_W`=128.
- Sub-module `aes_rr_pick`:
  - combinational round-robin picker;
  - inputs `valid` [NUM_REQ] and `ptr`;
  - outputs `gnt_onehot`, `gnt_idx` and `any`.

## Test plan
- FIPS-197 vector: requester 2 offers key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff -> `resp_text`=69c4e0d86a7b0430d8cdb78070b4c55a, `resp_id`=2, `resp_err`=0, with `cipher_ld` exactly one cycle after accept.
- All 4 requesters valid continuously from reset -> grant order 0,1,2,3,0; no `req_ready` while `busy`=1.
- `resp_ready` held 0 for 10 cycles in RESP -> `resp_*` stable, no new accept; the next accept follows the handshake by one cycle.
- Spurious `cipher_done` pulses in IDLE and LOAD -> no `resp_valid`; state sequence unchanged.
- `rst` low asserted in BUSY -> all outputs at reset values the same cycle; the next job serves requester 0 first.
- With `AES_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8 and `cipher_done` suppressed -> `resp_valid`=1, `resp_err`=1, `resp_text`=0 after 8 BUSY cycles; `cipher_done` on cycle 8 gives a normal result instead.
